// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search upward from rr_ptr with wrap
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the closest requester to rr_ptr is assigned last.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    sum       = '0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one shared FIFO write port
// Optional per-requester beat counters enabled by FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 8,
  parameter type DTYPE   = logic [WIDTH-1:0],
  localparam int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  input  DTYPE               req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               fifo_wen,
  output DTYPE               fifo_data_in,
  input  logic               fifo_full,
  output logic [PTR_W-1:0]   grant_id,
  output logic               busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] beat_count [NUM_REQ]
`endif
);

  arb_state_e       state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             any_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            state  <= ST_BURST;
            owner  <= winner;
            rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        ST_BURST: begin
          if (fifo_wen && req_last[owner]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state == ST_BURST);
  assign grant_id     = owner;
  assign fifo_wen     = busy & req_valid[owner] & ~fifo_full;
  assign fifo_data_in = req_data[owner];

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[owner] = ~fifo_full;
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) beat_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_wen && owner == PTR_W'(i) && beat_count[i] != '1)
          beat_count[i] <= beat_count[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-003 SHALL have parameter type DTYPE, default logic[WIDTH-1:0], giving the beat type.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-007 SHALL have port req_last, input, NUM_REQ, per-requester last beat of burst.
REQ-008 SHALL have port req_data, input, NUM_REQ x DTYPE, per-requester beat data.
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester beat accepted when valid and ready.
REQ-010 SHALL have port fifo_wen, output, 1, write enable to the shared FIFO.
REQ-011 SHALL have port fifo_data_in, output, DTYPE, write data to the shared FIFO.
REQ-012 SHALL have port fifo_full, input, 1, shared FIFO full flag.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ) (min 1), index of current burst owner.
REQ-014 SHALL have port busy, output, 1, high while a burst owns the FIFO.

Function
REQ-015 SHALL implement FSM with states IDLE and BURST; reset state IDLE.
REQ-016 In IDLE with any req_valid high, SHALL pick a winner round-robin, searching upward from pointer rr_ptr with wrap, register owner, and enter BURST next cycle (1-cycle arbitration latency).
REQ-017 On grant to requester k, SHALL set rr_ptr to (k+1) mod NUM_REQ.
REQ-018 In IDLE, req_ready SHALL be all-zero and fifo_wen 0.
REQ-019 In BURST, req_ready[owner] SHALL equal !fifo_full; all other req_ready bits 0.
REQ-020 fifo_wen SHALL equal BURST & req_valid[owner] & !fifo_full, combinationally, same cycle.
REQ-021 fifo_data_in SHALL equal req_data[owner] at all times (don't-care when fifo_wen low).
REQ-022 Accepted beat with req_last[owner] high SHALL return FSM to IDLE next cycle; one idle bubble between bursts.
REQ-023 fifo_full high in BURST SHALL stall without losing ownership; no beat is dropped or duplicated.
REQ-024 req_valid[owner] low mid-burst SHALL hold BURST indefinitely (no timeout).
REQ-025 Single-beat burst (last on first beat) SHALL be legal.
REQ-026 With NUM_REQ=1, SHALL behave as pass-through with the IDLE bubble; rr_ptr stays 0.
REQ-027 busy SHALL be high iff state is BURST; grant_id SHALL show registered owner.

Reset
REQ-028 Assertion of rst_n SHALL immediately force IDLE, owner 0, rr_ptr 0, and all outputs (req_ready, fifo_wen, grant_id, busy, stats) to 0, including mid-burst; a partially written burst is abandoned.

Configuration
REQ-029 Macro FIFO_ARB_STATS_EN defined SHALL add output beat_count, NUM_REQ x 16 bits, counting accepted beats per requester, saturating at 16'hFFFF, reset to 0.
REQ-030 Without FIFO_ARB_STATS_EN, beat_count port and its counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state enum typedef and the stats counter width constant (16).
REQ-032 Sub-module rr_picker SHALL implement the combinational round-robin search (inputs request vector and rr_ptr; outputs winner index and any-valid flag).

Verification
REQ-033 Reset then req_valid=4'b0101, last=1 each -> grant_id 0 then 2 then 0, each burst one beat, one IDLE cycle between.
REQ-034 Requester 1 burst of 3 beats (0xA1,0xA2,0xA3) while req 3 valid -> FIFO receives A1,A2,A3 contiguously, req_ready[3]=0 until burst ends, then grant_id=3.
REQ-035 fifo_full held high 5 cycles mid-burst -> fifo_wen 0, owner unchanged, remaining beats written in order after release.
REQ-036 rst_n asserted during beat 2 of a 4-beat burst -> same-cycle busy=0, fifo_wen=0; after release first grant searches from 0.
REQ-037 All 4 requesters continuously valid with single-beat bursts for 16 grants -> each granted exactly 4 times in order 0,1,2,3.
REQ-038 With FIFO_ARB_STATS_EN, 70000 beats from requester 0 -> beat_count[0]=16'hFFFF, others 0.
